// File: rtl/coupled_pkg.sv
// Shared types and constants for the coupled-column weight controller.
package coupled_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_RESP   = 2'd2,
        ST_CLEAR  = 2'd3
    } state_e;

    localparam logic [31:0] READ_MISS = 32'hAAAA_AAAA;

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'(1) << r) < 64'(v)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/coupled_col_match.sv
// Combinational address decoder: maps an unordered spin pair onto the column cell
// that couples it, if any.
module coupled_col_match
    import coupled_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned K     = 0,
    parameter int unsigned IDX_W = 2
) (
    input  logic [15:0]      s_i,
    input  logic [15:0]      d_i,
    output logic             hit_o,
    output logic [IDX_W-1:0] idx_o
);

    localparam int unsigned C = N / 2;

    // Odd distances pair spins in blocks of four so every spin appears exactly once.
    function automatic int unsigned src_of(input int unsigned c);
        if ((K % 2) == 0) begin
            return 2 * c;
        end
        return 4 * (c / 2) + (c % 2);
    endfunction

    function automatic int unsigned dst_of(input int unsigned c);
        return (src_of(c) + K + 1) % N;
    endfunction

    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        for (int unsigned c = 0; c < C; c++) begin
            if (((s_i == 16'(src_of(c))) && (d_i == 16'(dst_of(c)))) ||
                ((s_i == 16'(dst_of(c))) && (d_i == 16'(src_of(c))))) begin
                hit_o = 1'b1;
                idx_o = IDX_W'(c);
            end
        end
    end

endmodule

// File: rtl/coupled_col_ctrl.sv
// Weight store and access controller for one coupling column of an Ising array.
// Optional macro COUPLED_COL_MISS_CNT_EN adds a saturating miss counter port.
module coupled_col_ctrl
    import coupled_pkg::*;
#(
    parameter int unsigned N           = 8,
    parameter int unsigned K           = 0,
    parameter int unsigned NUM_WEIGHTS = 5,
    parameter int unsigned WEIGHT_W    = 3
) (
    input  logic                        clk,
    input  logic                        axi_rstn,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_wr,
    input  logic [15:0]                 s_addr,
    input  logic [15:0]                 d_addr,
    input  logic [31:0]                 wdata,
    output logic [31:0]                 rdata,
    output logic                        rvalid,
    input  logic                        clr_req,
    output logic                        busy,
`ifdef COUPLED_COL_MISS_CNT_EN
    output logic [15:0]                 miss_cnt,
`endif
    output logic [N/2*WEIGHT_W-1:0]     weights
);

    localparam int unsigned C     = N / 2;
    localparam int unsigned IDX_W = (clog2(C) > 0) ? clog2(C) : 1;
    localparam logic [WEIGHT_W-1:0] MAX_CODE = WEIGHT_W'(NUM_WEIGHTS - 1);
    localparam logic [WEIGHT_W-1:0] DEF_CODE = WEIGHT_W'((NUM_WEIGHTS - 1) / 2);

    state_e                         state_q, state_d;
    logic                           wr_q, wr_d;
    logic [15:0]                    s_q, s_d;
    logic [15:0]                    d_q, d_d;
    logic [WEIGHT_W-1:0]            wlow_q, wlow_d;
    logic                           hit_q, hit_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [WEIGHT_W-1:0]            wval_q, wval_d;
    logic [31:0]                    rdata_q, rdata_d;
    logic                           rvalid_q, rvalid_d;
    logic                           busy_q, busy_d;
    logic [IDX_W-1:0]               clr_idx_q, clr_idx_d;
    logic [C-1:0][WEIGHT_W-1:0]     weights_q, weights_d;
`ifdef COUPLED_COL_MISS_CNT_EN
    logic [15:0]                    miss_cnt_q, miss_cnt_d;
`endif

    logic                           match_hit_c;
    logic [IDX_W-1:0]               match_idx_c;
    logic [WEIGHT_W-1:0]            clamped_c;
    logic                           unused_wdata_hi;

    assign unused_wdata_hi = ^wdata[31:WEIGHT_W];

    coupled_col_match #(
        .N     (N),
        .K     (K),
        .IDX_W (IDX_W)
    ) u_match (
        .s_i   (s_q),
        .d_i   (d_q),
        .hit_o (match_hit_c),
        .idx_o (match_idx_c)
    );

    assign clamped_c = (wlow_q > MAX_CODE) ? MAX_CODE : wlow_q;

    // Next-state and datapath updates
    always_comb begin
        state_d   = state_q;
        wr_d      = wr_q;
        s_d       = s_q;
        d_d       = d_q;
        wlow_d    = wlow_q;
        hit_d     = hit_q;
        idx_d     = idx_q;
        wval_d    = wval_q;
        rdata_d   = rdata_q;
        clr_idx_d = clr_idx_q;
        weights_d = weights_q;
`ifdef COUPLED_COL_MISS_CNT_EN
        miss_cnt_d = miss_cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    state_d   = ST_CLEAR;
                    clr_idx_d = '0;
                end else if (req_valid) begin
                    state_d = ST_LOOKUP;
                    wr_d    = req_wr;
                    s_d     = s_addr;
                    d_d     = d_addr;
                    wlow_d  = wdata[WEIGHT_W-1:0];
                end
            end
            ST_LOOKUP: begin
                state_d = ST_RESP;
                hit_d   = match_hit_c;
                idx_d   = match_idx_c;
                wval_d  = clamped_c;
                if (!match_hit_c) begin
                    rdata_d = READ_MISS;
                end else if (wr_q) begin
                    rdata_d = 32'(clamped_c);
                end else begin
                    rdata_d = 32'(weights_q[match_idx_c]);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                if (hit_q && wr_q) begin
                    weights_d[idx_q] = wval_q;
                end
`ifdef COUPLED_COL_MISS_CNT_EN
                if (!hit_q && (miss_cnt_q != 16'hFFFF)) begin
                    miss_cnt_d = miss_cnt_q + 16'd1;
                end
`endif
            end
            ST_CLEAR: begin
                weights_d[clr_idx_q] = DEF_CODE;
                if (clr_idx_q == IDX_W'(C - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    clr_idx_d = clr_idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        rvalid_d = (state_d == ST_RESP);
        busy_d   = (state_d == ST_CLEAR);
    end

    always_ff @(posedge clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            state_q   <= ST_IDLE;
            wr_q      <= 1'b0;
            s_q       <= '0;
            d_q       <= '0;
            wlow_q    <= '0;
            hit_q     <= 1'b0;
            idx_q     <= '0;
            wval_q    <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            busy_q    <= 1'b0;
            clr_idx_q <= '0;
            weights_q <= {C{DEF_CODE}};
`ifdef COUPLED_COL_MISS_CNT_EN
            miss_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            wr_q      <= wr_d;
            s_q       <= s_d;
            d_q       <= d_d;
            wlow_q    <= wlow_d;
            hit_q     <= hit_d;
            idx_q     <= idx_d;
            wval_q    <= wval_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            busy_q    <= busy_d;
            clr_idx_q <= clr_idx_d;
            weights_q <= weights_d;
`ifdef COUPLED_COL_MISS_CNT_EN
            miss_cnt_q <= miss_cnt_d;
`endif
        end
    end

    // A pending clear blocks new requests in the same cycle it is raised.
    assign req_ready = (state_q == ST_IDLE) && !clr_req;
    assign rdata     = rdata_q;
    assign rvalid    = rvalid_q;
    assign busy      = busy_q;
    assign weights   = weights_q;
`ifdef COUPLED_COL_MISS_CNT_EN
    assign miss_cnt  = miss_cnt_q;
`endif

endmodule

// File: tb/tb_coupled_col_ctrl.sv
// Self-checking bench: two controllers (K=0 and K=1) share stimulus and are each
// compared against a table-driven weight model.
module tb_coupled_col_ctrl;

    logic        clk = 1'b0;
    logic        axi_rstn;
    logic        req_valid, req_wr, clr_req;
    logic [15:0] s_addr, d_addr;
    logic [31:0] wdata;

    logic        req_ready0, req_ready1, rvalid0, rvalid1, busy0, busy1;
    logic [31:0] rdata0, rdata1;
    logic [11:0] w0, w1;
`ifdef COUPLED_COL_MISS_CNT_EN
    logic [15:0] mc0, mc1;
`endif

    int checks   = 0;
    int failures = 0;

    int          wt[2][4];
    int          miss[2];
    int          lat_o[2];
    int          pulses_o[2];
    logic [31:0] rd_o[2];
    logic [31:0] exp_o[2];

    always #5 clk = ~clk;

    coupled_col_ctrl #(.N(8), .K(0), .NUM_WEIGHTS(5), .WEIGHT_W(3)) dut0 (
        .clk(clk), .axi_rstn(axi_rstn), .req_valid(req_valid), .req_ready(req_ready0),
        .req_wr(req_wr), .s_addr(s_addr), .d_addr(d_addr), .wdata(wdata),
        .rdata(rdata0), .rvalid(rvalid0), .clr_req(clr_req), .busy(busy0),
`ifdef COUPLED_COL_MISS_CNT_EN
        .miss_cnt(mc0),
`endif
        .weights(w0)
    );

    coupled_col_ctrl #(.N(8), .K(1), .NUM_WEIGHTS(5), .WEIGHT_W(3)) dut1 (
        .clk(clk), .axi_rstn(axi_rstn), .req_valid(req_valid), .req_ready(req_ready1),
        .req_wr(req_wr), .s_addr(s_addr), .d_addr(d_addr), .wdata(wdata),
        .rdata(rdata1), .rvalid(rvalid1), .clr_req(clr_req), .busy(busy1),
`ifdef COUPLED_COL_MISS_CNT_EN
        .miss_cnt(mc1),
`endif
        .weights(w1)
    );

    // Pair table for an 8-spin column: instance index equals K.
    function automatic int cell_of(input int k, input int a, input int b);
        int pairs_k0[4][2] = '{'{0, 1}, '{2, 3}, '{4, 5}, '{6, 7}};
        int pairs_k1[4][2] = '{'{0, 2}, '{1, 3}, '{4, 6}, '{5, 7}};
        for (int c = 0; c < 4; c++) begin
            int p = (k == 0) ? pairs_k0[c][0] : pairs_k1[c][0];
            int q = (k == 0) ? pairs_k0[c][1] : pairs_k1[c][1];
            if ((a == p && b == q) || (a == q && b == p)) return c;
        end
        return -1;
    endfunction

    function automatic logic [31:0] model_access(input int i, input bit wr, input int a,
                                                 input int b, input logic [31:0] wd);
        int c;
        int v;
        c = cell_of(i, a, b);
        if (c < 0) begin
            miss[i] = miss[i] + 1;
            return 32'hAAAAAAAA;
        end
        if (wr) begin
            v = int'(wd[2:0]);
            if (v > 4) v = 4;
            wt[i][c] = v;
            return 32'(v);
        end
        return 32'(wt[i][c]);
    endfunction

    function automatic logic [11:0] exp_w(input int i);
        logic [11:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) r[c*3 +: 3] = 3'(wt[i][c]);
        return r;
    endfunction

    function automatic logic [11:0] obs_w(input int i);
        return (i == 0) ? w0 : w1;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            miss[i] = 0;
            for (int c = 0; c < 4; c++) wt[i][c] = 2;
        end
    endfunction

    // One request on both instances; observes 4 falling edges after the handshake.
    task automatic run_req(input bit wr, input int a, input int b, input logic [31:0] wd);
        @(negedge clk);
        req_valid = 1'b1;
        req_wr    = wr;
        s_addr    = 16'(a);
        d_addr    = 16'(b);
        wdata     = wd;
        for (int i = 0; i < 2; i++) begin
            exp_o[i]    = model_access(i, wr, a, b, wd);
            lat_o[i]    = 0;
            pulses_o[i] = 0;
            rd_o[i]     = '0;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            if (rvalid0) begin
                pulses_o[0]++;
                if (lat_o[0] == 0) begin lat_o[0] = n; rd_o[0] = rdata0; end
            end
            if (rvalid1) begin
                pulses_o[1]++;
                if (lat_o[1] == 0) begin lat_o[1] = n; rd_o[1] = rdata1; end
            end
        end
    endtask

    task automatic apply_reset();
        axi_rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        axi_rstn = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        req_valid = 1'b0; req_wr = 1'b0; clr_req = 1'b0;
        s_addr = '0; d_addr = '0; wdata = '0;
        apply_reset();
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs_w(i) !== 12'o2222) begin
                failures++;
                $display("FAIL reset_weights inst%0d got %o exp %o", i, obs_w(i), 12'o2222);
            end
        end
        checks++;
        if ({req_ready0, req_ready1, rvalid0, rvalid1, busy0, busy1} !== 6'b110000) begin
            failures++;
            $display("FAIL reset_flags got %b exp 110000",
                     {req_ready0, req_ready1, rvalid0, rvalid1, busy0, busy1});
        end
        checks++;
        if ({rdata0, rdata1} !== 64'd0) begin
            failures++;
            $display("FAIL reset_rdata got %h %h exp 0", rdata0, rdata1);
        end
    endtask

    task automatic check_op(input string tag);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (lat_o[i] !== 2 || pulses_o[i] !== 1) begin
                failures++;
                $display("FAIL %s_latency inst%0d got lat=%0d pulses=%0d exp lat=2 pulses=1",
                         tag, i, lat_o[i], pulses_o[i]);
            end
            checks++;
            if (rd_o[i] !== exp_o[i]) begin
                failures++;
                $display("FAIL %s_rdata inst%0d got %h exp %h", tag, i, rd_o[i], exp_o[i]);
            end
            checks++;
            if (obs_w(i) !== exp_w(i)) begin
                failures++;
                $display("FAIL %s_weights inst%0d got %o exp %o", tag, i, obs_w(i), exp_w(i));
            end
        end
    endtask

    task automatic test_directed();
        run_req(1'b1, 3, 2, 32'd4);
        check_op("k0_write");
        run_req(1'b0, 2, 3, 32'd0);
        check_op("k0_read");
        checks++;
        if (rdata0 !== 32'd4) begin
            failures++;
            $display("FAIL rdata_hold got %h exp 00000004", rdata0);
        end
        run_req(1'b1, 5, 7, 32'd7);
        check_op("k1_clamp");
        run_req(1'b1, 0, 1, 32'd3);
        check_op("k1_miss");
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            int a = int'($urandom_range(0, 7));
            int b = int'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) a = int'($urandom_range(8, 65535));
            run_req(1'(($urandom_range(0, 1))), a, b, $urandom);
            check_op("random");
        end
    endtask

    task automatic test_clear();
        int pa[8] = '{0, 2, 4, 6, 0, 1, 4, 5};
        int pb[8] = '{1, 3, 5, 7, 2, 3, 6, 7};
        int busy_cnt[2];
        int bad_ready;
        int rv_cnt;
        for (int n = 0; n < 8; n++) run_req(1'b1, pa[n], pb[n], 32'd4);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs_w(i) !== exp_w(i)) begin
                failures++;
                $display("FAIL fill_weights inst%0d got %o exp %o", i, obs_w(i), exp_w(i));
            end
        end
        for (int pass = 0; pass < 2; pass++) begin
            busy_cnt = '{0, 0};
            bad_ready = 0;
            rv_cnt = 0;
            @(negedge clk);
            clr_req = 1'b1;
            if (pass == 1) begin
                req_valid = 1'b1; req_wr = 1'b1; s_addr = 16'd0; d_addr = 16'd1; wdata = 32'd4;
            end
            #1;
            checks++;
            if ({req_ready0, req_ready1} !== 2'b00) begin
                failures++;
                $display("FAIL clr_blocks_ready pass%0d got %b exp 00", pass, {req_ready0, req_ready1});
            end
            @(posedge clk);
            #1 clr_req = 1'b0;
            req_valid = 1'b0;
            for (int n = 0; n < 8; n++) begin
                @(negedge clk);
                if (busy0) busy_cnt[0]++;
                if (busy1) busy_cnt[1]++;
                if ((busy0 && req_ready0) || (busy1 && req_ready1)) bad_ready++;
                if (rvalid0 || rvalid1) rv_cnt++;
            end
            model_reset();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (busy_cnt[i] !== 4) begin
                    failures++;
                    $display("FAIL clr_busy_cycles pass%0d inst%0d got %0d exp 4", pass, i, busy_cnt[i]);
                end
                checks++;
                if (obs_w(i) !== exp_w(i)) begin
                    failures++;
                    $display("FAIL clr_weights pass%0d inst%0d got %o exp %o", pass, i, obs_w(i), exp_w(i));
                end
            end
            checks++;
            if (bad_ready !== 0 || rv_cnt !== 0) begin
                failures++;
                $display("FAIL clr_ready_rvalid pass%0d got bad_ready=%0d rvalid=%0d exp 0 0",
                         pass, bad_ready, rv_cnt);
            end
        end
    endtask

    task automatic test_clr_ignored();
        int busy_seen = 0;
        int rv_at = 0;
        @(negedge clk);
        req_valid = 1'b1; req_wr = 1'b1; s_addr = 16'd2; d_addr = 16'd3; wdata = 32'd1;
        for (int i = 0; i < 2; i++) exp_o[i] = model_access(i, 1'b1, 2, 3, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        clr_req = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            if (rvalid0 && rv_at == 0) rv_at = n;
            if (busy0 || busy1) busy_seen++;
            if (n == 2) begin
                @(posedge clk);
                #1 clr_req = 1'b0;
            end
        end
        checks++;
        if (rv_at !== 2 || busy_seen !== 0) begin
            failures++;
            $display("FAIL clr_ignored got rvalid_at=%0d busy=%0d exp 2 0", rv_at, busy_seen);
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs_w(i) !== exp_w(i)) begin
                failures++;
                $display("FAIL clr_ignored_weights inst%0d got %o exp %o", i, obs_w(i), exp_w(i));
            end
        end
    endtask

    task automatic test_reset_mid();
        int rv_cnt = 0;
        @(negedge clk);
        req_valid = 1'b1; req_wr = 1'b1; s_addr = 16'd0; d_addr = 16'd1; wdata = 32'd4;
        @(posedge clk);
        #1 req_valid = 1'b0;
        axi_rstn = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs_w(i) !== exp_w(i)) begin
                failures++;
                $display("FAIL midreset_weights inst%0d got %o exp %o", i, obs_w(i), exp_w(i));
            end
        end
        @(negedge clk);
        axi_rstn = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (rvalid0 || rvalid1) rv_cnt++;
        end
        checks++;
        if (rv_cnt !== 0 || rdata0 !== 32'd0 || obs_w(0) !== exp_w(0)) begin
            failures++;
            $display("FAIL midreset_no_resp got rvalid=%0d rdata=%h w=%o exp 0 0 %o",
                     rv_cnt, rdata0, obs_w(0), exp_w(0));
        end
`ifdef COUPLED_COL_MISS_CNT_EN
        for (int n = 0; n < 3; n++) run_req(1'b0, 100 + n, 200, 32'd0);
        checks++;
        if (mc0 !== 16'(miss[0]) || mc1 !== 16'(miss[1])) begin
            failures++;
            $display("FAIL miss_cnt got %0d %0d exp %0d %0d", mc0, mc1, miss[0], miss[1]);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_clear();
        test_clr_ignored();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/coupled_col_ctrl.md
COUPLED_COL_CTRL -- requirements
Module: coupled_col_ctrl

Interface
REQ-001 SHALL have parameter N, default 8, spin count (even, >=4; multiple of 4 when K odd).
REQ-002 SHALL have parameter K, default 0, column index selecting coupling distance K+1.
REQ-003 SHALL have parameter NUM_WEIGHTS, default 5, number of legal weight codes.
REQ-004 SHALL have parameter WEIGHT_W, default 3, weight field width (>= clog2(NUM_WEIGHTS)).
REQ-005 SHALL have port clk  in  1  sole clock; one clock, all state on its rising edge.
REQ-006 SHALL have port axi_rstn  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port req_valid  in  1  access request.
REQ-008 SHALL have port req_ready  out  1  controller can accept a request.
REQ-009 SHALL have port req_wr  in  1  1 = write, 0 = read.
REQ-010 SHALL have ports s_addr, d_addr  in  16 each  spin pair addressed.
REQ-011 SHALL have port wdata  in  32  write data; bits [WEIGHT_W-1:0] used.
REQ-012 SHALL have port rdata  out  32  response data; port rvalid  out  1  one-cycle response strobe.
REQ-013 SHALL have port clr_req  in  1  reset all weights to default; port busy  out  1  clear in progress.
REQ-014 SHALL have port weights  out  N/2*WEIGHT_W  cell c weight at [c*WEIGHT_W +: WEIGHT_W].

Function
REQ-015 Cell count C = N/2; cell c source s(c) = 2c when K even, 4*(c/2)+(c%2) when K odd; dest d(c) = (s(c)+K+1) mod N.
REQ-016 Cell c matches when (s_addr,d_addr) equals (s(c),d(c)) or (d(c),s(c)); at most one match; none = miss.
REQ-017 FSM states IDLE, LOOKUP, RESP, CLEAR; reset state IDLE.
REQ-018 req_ready = 1 only in IDLE with clr_req low; handshake = req_valid & req_ready.
REQ-019 IDLE: clr_req high -> CLEAR (priority over req_valid); else handshake -> LOOKUP, capturing req_wr, addresses, wdata.
REQ-020 LOOKUP -> RESP unconditionally, registering match flag and cell index.
REQ-021 RESP: write hit stores min(wdata[WEIGHT_W-1:0], NUM_WEIGHTS-1); rvalid=1 for one cycle; -> IDLE.
REQ-022 rdata in RESP: hit read = stored weight zero-extended; hit write = clamped value stored; miss = 32'hAAAAAAAA; weights unchanged on miss.
REQ-023 Latency: handshake edge t -> rvalid high cycle t+2; next accept earliest t+3.
REQ-024 CLEAR: index 0..C-1 one cell per cycle set to DEFAULT=(NUM_WEIGHTS-1)/2; busy=1 throughout; after cell C-1 -> IDLE.
REQ-025 clr_req sampled only in IDLE; held high restarts clear; ignored in LOOKUP/RESP.
REQ-026 rdata holds last value between rvalid pulses; weights is registered, changes only in RESP/CLEAR.

Reset
REQ-027 axi_rstn low asynchronously: state IDLE, all weights DEFAULT, rdata 0, rvalid 0, busy 0, req_ready 1 on release.
REQ-028 Reset mid-LOOKUP/RESP/CLEAR aborts with no response and no further weight update.

Configuration
REQ-029 Macro COUPLED_COL_MISS_CNT_EN defined: extra port miss_cnt out 16, counts RESP misses, saturates at 16'hFFFF, reset 0.
REQ-030 Macro undefined: no miss_cnt port, no counter logic; all other behaviour identical.

Structure
REQ-031 Package coupled_pkg SHALL hold FSM state enum, READ_MISS constant 32'hAAAAAAAA, clog2 function.
REQ-032 Sub-module coupled_col_match (combinational): addresses -> hit flag and cell index per REQ-015/016.

Verification (N=8, NUM_WEIGHTS=5, WEIGHT_W=3)
REQ-033 After reset, K=0: weights = 12'o2222 (all cells 2), req_ready=1.
REQ-034 K=0, write s=3,d=2, wdata=4 -> rvalid at t+2, rdata=4, cell 1 = 4; read s=2,d=3 -> rdata=4.
REQ-035 K=1, write s=5,d=7, wdata=7 -> stored 4 (clamp) in cell 3; write s=0,d=1 -> rdata 32'hAAAAAAAA, weights unchanged.
REQ-036 Set all cells 4, pulse clr_req in IDLE -> busy 4 cycles, req_ready=0, all cells 2 afterwards; clr_req and req_valid same cycle -> clear wins.
REQ-037 Assert axi_rstn low during LOOKUP -> no rvalid, weights DEFAULT; with COUPLED_COL_MISS_CNT_EN, 3 misses -> miss_cnt=3.
